// File: rtl/timer_pkg.sv
// Shared register map, CONFIG layout, mode encodings and controller FSM states
// for the timer block (also imported by dev_timer).
package timer_pkg;

  localparam logic [4:0] ADDR_PEND = 5'h10;
  localparam logic [4:0] ADDR_MASK = 5'h11;
  localparam int         CFG_W     = 8;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_CTC    = 2'd1,
    MODE_SPWM   = 2'd2,
    MODE_DPWM   = 2'd3
  } timer_mode_t;

  typedef enum logic [1:0] {
    OMODE_NONE   = 2'd0,
    OMODE_TOGGLE = 2'd1,
    OMODE_RSVD   = 2'd2,
    OMODE_INVERT = 2'd3
  } out_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_QUIESCE = 2'd2,
    ST_ACK     = 2'd3
  } ctrl_state_t;

  // Bit layout of a CONFIG register: [7] en, [6:5] output_mode,
  // [4:3] timer_mode, [2:0] clk_source.
  typedef struct packed {
    logic       en;
    logic [1:0] output_mode;
    logic [1:0] timer_mode;
    logic [2:0] clk_source;
  } cfg_t;

endpackage

// File: rtl/timer_irq_ctrl.sv
// Match-edge detection, write-1-to-clear pending bits, interrupt mask and
// registered interrupt request for NCH timer channels.
module timer_irq_ctrl #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] int_match,
  input  logic [NCH-1:0] ch_en,
  input  logic           clr_we,
  input  logic [NCH-1:0] clr_bits,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_bits,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] mask,
  output logic           irq
);

  logic [NCH-1:0] match_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] clr;

  assign rise = int_match & ~match_q & ch_en;
  assign clr  = clr_we ? clr_bits : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= '0;
      pend    <= '0;
      mask    <= '0;
      irq     <= 1'b0;
    end else begin
      match_q <= int_match;
      // A new edge outranks a simultaneous clear of the same bit.
      pend    <= (pend & ~clr) | rise;
      if (mask_we) mask <= mask_bits;
      irq     <= |(pend & mask);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Bus-facing register block for up to four timer channels: CONFIG/MATCH per
// channel, pending/mask interrupt registers, and quiesced reconfiguration.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int TIMER_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stb,
  input  logic                      we,
  input  logic [4:0]                addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      ack,
  output logic [3*NCH-1:0]          ch_clk_source,
  output logic [2*NCH-1:0]          ch_timer_mode,
  output logic [2*NCH-1:0]          ch_output_mode,
  output logic [TIMER_BITS*NCH-1:0] ch_match,
  output logic [NCH-1:0]            ch_reset,
  input  logic [NCH-1:0]            ch_int_match,
  output logic                      irq
);

  ctrl_state_t           state, state_nxt;
  cfg_t                  cfg_q   [NCH];
  logic [TIMER_BITS-1:0] match_q [NCH];
  logic [NCH-1:0]        cfg_en;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_val;
  logic [2:0]            q_ch;
  logic                  q_cnt;
  logic [NCH-1:0]        pend, mask;
  logic [2:0]            ch_idx;
  logic                  in_access;
  logic                  wr_cfg, wr_match, wr_pend, wr_mask;
  logic                  need_quiesce;
  cfg_t                  new_cfg;
  logic                  unused_wdata;

  assign ch_idx    = addr[3:1];
  assign in_access = (state == ST_ACCESS);
  assign wr_cfg    = in_access && we && !addr[4] && !addr[0];
  assign wr_match  = in_access && we && !addr[4] &&  addr[0];
  assign wr_pend   = in_access && we && (addr == ADDR_PEND);
  assign wr_mask   = in_access && we && (addr == ADDR_MASK);
  assign new_cfg   = cfg_t'(wdata[CFG_W-1:0]);
  assign unused_wdata = &{1'b0, wdata};

  always_comb begin
    for (int i = 0; i < NCH; i++) cfg_en[i] = cfg_q[i].en;
  end

  // Reclocking or re-moding a running channel must hold its timer in reset.
  always_comb begin
    need_quiesce = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_cfg && ch_idx == 3'(i) && cfg_q[i].en &&
          (new_cfg.clk_source != cfg_q[i].clk_source ||
           new_cfg.timer_mode != cfg_q[i].timer_mode))
        need_quiesce = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (!addr[4]) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == 3'(i))
          rd_val = addr[0] ? 32'(match_q[i]) : {24'b0, cfg_q[i]};
      end
    end else if (addr == ADDR_PEND) begin
      rd_val = 32'(pend);
    end else if (addr == ADDR_MASK) begin
      rd_val = 32'(mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (stb) state_nxt = ST_ACCESS;
      ST_ACCESS:  state_nxt = need_quiesce ? ST_QUIESCE : ST_ACK;
      ST_QUIESCE: if (q_cnt) state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack   = (state == ST_ACK);
    rdata = ack ? rdata_q : '0;
    for (int i = 0; i < NCH; i++) begin
      ch_reset[i] = !cfg_q[i].en || (state == ST_QUIESCE && q_ch == 3'(i));
      ch_clk_source[3*i +: 3]            = cfg_q[i].clk_source;
      ch_timer_mode[2*i +: 2]            = cfg_q[i].timer_mode;
      ch_output_mode[2*i +: 2]           = cfg_q[i].output_mode;
      ch_match[TIMER_BITS*i +: TIMER_BITS] = match_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cfg_q[i]   <= '0;
        match_q[i] <= '0;
      end
      rdata_q <= '0;
      q_ch    <= '0;
      q_cnt   <= 1'b0;
    end else begin
      // q_cnt marks the second QUIESCE cycle.
      q_cnt <= (state == ST_QUIESCE) ? ~q_cnt : 1'b0;
      if (in_access) begin
        rdata_q <= we ? '0 : rd_val;
        q_ch    <= ch_idx;
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_cfg && ch_idx == 3'(i))   cfg_q[i]   <= new_cfg;
        if (wr_match && ch_idx == 3'(i)) match_q[i] <= wdata[TIMER_BITS-1:0];
      end
    end
  end

  timer_irq_ctrl #(.NCH(NCH)) u_irq (
    .clk       (clk),
    .reset     (reset),
    .int_match (ch_int_match),
    .ch_en     (cfg_en),
    .clr_we    (wr_pend),
    .clr_bits  (wdata[NCH-1:0]),
    .mask_we   (wr_mask),
    .mask_bits (wdata[NCH-1:0]),
    .pend      (pend),
    .mask      (mask),
    .irq       (irq)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, directed interrupt/reset
// sequences and randomized bus traffic against a register-level model.
module tb_timer_ctrl;

  localparam int NCH = 4;
  localparam int TB  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stb = 1'b0;
  logic              we = 1'b0;
  logic [4:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              ack;
  logic [3*NCH-1:0]  ch_clk_source;
  logic [2*NCH-1:0]  ch_timer_mode;
  logic [2*NCH-1:0]  ch_output_mode;
  logic [TB*NCH-1:0] ch_match;
  logic [NCH-1:0]    ch_reset;
  logic [NCH-1:0]    ch_int_match = '0;
  logic              irq;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.NCH(NCH), .TIMER_BITS(TB)) dut (
    .clk(clk), .reset(reset), .stb(stb), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .ch_clk_source(ch_clk_source),
    .ch_timer_mode(ch_timer_mode), .ch_output_mode(ch_output_mode),
    .ch_match(ch_match), .ch_reset(ch_reset), .ch_int_match(ch_int_match),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One bus transaction; returns read data, latency in cycles from stb rise
  // to ack, and how many of those cycles had ch_reset[0] high.
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [NCH-1:0] inj, output logic [31:0] rd,
                     output int lat, output int rst0);
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; rst0 = 0; rd = '0;
    while (1) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (lat == 1) ch_int_match = ch_int_match | inj;
      if (ch_reset[0]) rst0++;
      if (ack) begin
        rd = rdata;
        break;
      end
      if (lat >= 20) begin
        checks++; errors++;
        $display("FAIL bus_timeout: no ack after %0d cycles, required within 4", lat);
        break;
      end
    end
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  // Register-level reference model
  logic [7:0]     m_cfg   [NCH];
  logic [TB-1:0]  m_match [NCH];
  logic [NCH-1:0] m_pend, m_mask;

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin m_cfg[i] = '0; m_match[i] = '0; end
    m_pend = '0; m_mask = '0;
  endtask

  task automatic model_txn(input logic w, input logic [4:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
    int c;
    c = int'(a[3:1]);
    rd = '0; lat = 2;
    if (!a[4]) begin
      if (c < NCH) begin
        if (!w) rd = a[0] ? 32'(m_match[c]) : 32'(m_cfg[c]);
        else if (a[0]) m_match[c] = d[TB-1:0];
        else begin
          if (m_cfg[c][7] && d[4:0] != m_cfg[c][4:0]) lat = 4;
          m_cfg[c] = d[7:0];
        end
      end
    end else if (a == 5'h10) begin
      if (!w) rd = 32'(m_pend); else m_pend = m_pend & ~d[NCH-1:0];
    end else if (a == 5'h11) begin
      if (!w) rd = 32'(m_mask); else m_mask = d[NCH-1:0];
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [TB*NCH-1:0] em;
    logic [NCH-1:0]    er;
    logic [3*NCH-1:0]  ec;
    logic [2*NCH-1:0]  et, eo;
    for (int i = 0; i < NCH; i++) begin
      em[TB*i +: TB] = m_match[i];
      er[i]          = ~m_cfg[i][7];
      ec[3*i +: 3]   = m_cfg[i][2:0];
      et[2*i +: 2]   = m_cfg[i][4:3];
      eo[2*i +: 2]   = m_cfg[i][6:5];
    end
    check({tag, "_match"}, 64'(ch_match), 64'(em));
    check({tag, "_chrst"}, 64'(ch_reset), 64'(er));
    check({tag, "_cfgout"}, {28'(ch_clk_source), 8'(ch_timer_mode), 8'(ch_output_mode)},
          {28'(ec), 8'(et), 8'(eo)});
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    int          lat;
    int          rst;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [31:0] rd, erd;
    int lat, rst0, elat, c;
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;

    tbl[0]  = '{1'b1, 5'h01, 32'h0000_1234, 32'h0, 2, 2};
    tbl[1]  = '{1'b0, 5'h01, 32'h0,         32'h1234, 2, 2};
    tbl[2]  = '{1'b1, 5'h03, 32'hFFFF_ABCD, 32'h0, 2, 2};
    tbl[3]  = '{1'b0, 5'h03, 32'h0,         32'hABCD, 2, 2};
    tbl[4]  = '{1'b1, 5'h00, 32'h0000_0080, 32'h0, 2, 1};
    tbl[5]  = '{1'b1, 5'h00, 32'h0000_0089, 32'h0, 4, 2};
    tbl[6]  = '{1'b0, 5'h00, 32'h0,         32'h89, 2, 0};
    tbl[7]  = '{1'b1, 5'h00, 32'hFFFF_FFE9, 32'h0, 2, 0};
    tbl[8]  = '{1'b0, 5'h00, 32'h0,         32'hE9, 2, 0};
    tbl[9]  = '{1'b0, 5'h1F, 32'h0,         32'h0, 2, 0};
    tbl[10] = '{1'b1, 5'h0A, 32'h0000_00FF, 32'h0, 2, 0};
    tbl[11] = '{1'b0, 5'h0A, 32'h0,         32'h0, 2, 0};
    tbl[12] = '{1'b0, 5'h0B, 32'h0,         32'h0, 2, 0};
    tbl[13] = '{1'b1, 5'h11, 32'h0000_000F, 32'h0, 2, 0};
    tbl[14] = '{1'b0, 5'h11, 32'h0,         32'hF, 2, 0};
    tbl[15] = '{1'b1, 5'h11, 32'h0000_0001, 32'h0, 2, 0};
    tbl[16] = '{1'b0, 5'h11, 32'h0,         32'h1, 2, 0};
    tbl[17] = '{1'b0, 5'h10, 32'h0,         32'h0, 2, 0};
    tbl[18] = '{1'b1, 5'h15, 32'hFFFF_FFFF, 32'h0, 2, 0};
    tbl[19] = '{1'b0, 5'h15, 32'h0,         32'h0, 2, 0};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_chrst", 64'(ch_reset), 64'hF);
    check("rst_match", 64'(ch_match), 64'h0);
    check("rst_mode", 64'(ch_timer_mode), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].d, '0, rd, lat, rst0);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("vec%0d_rst0", i), 64'(rst0), 64'(tbl[i].rst));
      if (!tbl[i].w) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].rd));
    end
    check("tbl_match_out", 64'(ch_match), 64'h0000_0000_ABCD_1234);
    check("tbl_cfg0_out", {ch_clk_source[2:0], ch_timer_mode[1:0], ch_output_mode[1:0]},
          {3'd1, 2'd1, 2'd3});

    // Level held high sets pending once; mask=1, ch0 enabled.
    @(negedge clk); ch_int_match[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("irq_lag", 64'(irq), 64'h0);
    @(posedge clk); @(negedge clk);
    check("irq_set", 64'(irq), 64'h1);
    bus(1'b0, 5'h10, 32'h0, '0, rd, lat, rst0);
    check("pend_set", 64'(rd), 64'h1);
    bus(1'b1, 5'h10, 32'h1, '0, rd, lat, rst0);
    @(posedge clk); @(negedge clk);
    check("irq_clr", 64'(irq), 64'h0);
    bus(1'b0, 5'h10, 32'h0, '0, rd, lat, rst0);
    check("pend_held_level", 64'(rd), 64'h0);
    ch_int_match[0] = 1'b0;

    // Clear and new edge on ch1 in the same cycle: set wins.
    bus(1'b1, 5'h02, 32'h80, '0, rd, lat, rst0);
    @(negedge clk); ch_int_match[1] = 1'b1;
    @(negedge clk); ch_int_match[1] = 1'b0;
    @(negedge clk);
    bus(1'b1, 5'h10, 32'h2, 4'b0010, rd, lat, rst0);
    ch_int_match[1] = 1'b0;
    // Edge on disabled ch2 is ignored.
    @(negedge clk); ch_int_match[2] = 1'b1;
    @(negedge clk); ch_int_match[2] = 1'b0;
    bus(1'b0, 5'h10, 32'h0, '0, rd, lat, rst0);
    check("pend_set_wins", 64'(rd), 64'h2);

    // Reset during QUIESCE aborts the write.
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = 5'h00; wdata = 32'h91;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("quiesce_rst0", 64'(ch_reset[0]), 64'h1);
    reset = 1'b1;
    #1;
    check("abort_ack", 64'(ack), 64'h0);
    check("abort_chrst", 64'(ch_reset), 64'hF);
    check("abort_match", 64'(ch_match), 64'h0);
    @(negedge clk); stb = 1'b0; we = 1'b0;
    check("abort_noack", 64'(ack), 64'h0);
    @(negedge clk); reset = 1'b0;
    bus(1'b0, 5'h00, 32'h0, '0, rd, lat, rst0);
    check("post_abort_lat", 64'(lat), 64'h2);
    check("post_abort_rd", 64'(rd), 64'h0);

    // Randomized traffic against the model
    do_reset();
    model_clear();
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      d = $urandom;
      if (!a[4] && !a[0] && $urandom_range(0, 2) != 0) d[7] = 1'b1;
      model_txn(w, a, d, erd, elat);
      bus(w, a, d, '0, rd, lat, rst0);
      check($sformatf("rnd%0d_lat", n), 64'(lat), 64'(elat));
      if (!w) check($sformatf("rnd%0d_rdata", n), 64'(rd), 64'(erd));
      check_outputs($sformatf("rnd%0d", n));
      @(posedge clk); @(negedge clk);
      check($sformatf("rnd%0d_irq", n), 64'(irq), 64'(|(m_pend & m_mask)));
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, NCH - 1);
        ch_int_match[c] = 1'b1;
        @(posedge clk); @(negedge clk);
        ch_int_match[c] = 1'b0;
        if (m_cfg[c][7]) m_pend[c] = 1'b1;
        @(posedge clk); @(negedge clk);
        check($sformatf("rnd%0d_edge_irq", n), 64'(irq), 64'(|(m_pend & m_mask)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of timer channels controlled (1..4).
REQ-002 Parameter TIMER_BITS, default 16, timer counter/match width (<=32).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 stb  in  1  bus request; held high until ack.
REQ-006 we  in  1  1 = write, 0 = read; valid with stb.
REQ-007 addr  in  5  register address; valid with stb.
REQ-008 wdata  in  32  write data; valid with stb.
REQ-009 rdata  out  32  read data; valid in the ack cycle, 0 otherwise.
REQ-010 ack  out  1  one-cycle transaction-complete pulse.
REQ-011 ch_clk_source  out  3*NCH  per-channel clock-source select.
REQ-012 ch_timer_mode  out  2*NCH  per-channel mode (0 normal, 1 CTC, 2 SPWM, 3 DPWM).
REQ-013 ch_output_mode  out  2*NCH  per-channel output mode (1 toggle, 3 invert).
REQ-014 ch_match  out  TIMER_BITS*NCH  per-channel match value.
REQ-015 ch_reset  out  NCH  per-channel synchronous timer reset, active high.
REQ-016 ch_int_match  in  NCH  per-channel match level from the timers.
REQ-017 irq  out  1  registered OR of (pending & mask).

Function
REQ-018 Address map: addr[4]=0 -> channel addr[3:1], addr[0]=0 CONFIG, 1 MATCH; addr 0x10 PEND; 0x11 MASK; other addresses read 0, writes ignored, still acked.
REQ-019 CONFIG bits: [2:0] clk_source, [4:3] timer_mode, [6:5] output_mode, [7] en; remaining bits read 0; channel index >= NCH reads 0, writes ignored.
REQ-020 FSM states IDLE, ACCESS, QUIESCE, ACK; a transaction is accepted only in IDLE with stb=1.
REQ-021 IDLE->ACCESS on stb; ACCESS performs the read/write and goes to ACK, or to QUIESCE for a CONFIG write that changes clk_source or timer_mode on an enabled channel.
REQ-022 QUIESCE: ch_reset of the target channel high for exactly 2 cycles with new config already driven, then ACK.
REQ-023 ACK: ack=1 for one cycle, then IDLE; stb is ignored in ACK, so a back-to-back request is accepted in the following IDLE cycle.
REQ-024 Latency: reads and plain writes ack 2 cycles after stb rises; quiescing writes ack 4 cycles after.
REQ-025 ch_reset[i] is held high continuously while CONFIG.en[i]=0.
REQ-026 MATCH write updates ch_match immediately without a channel reset; only TIMER_BITS LSBs stored, upper bits read 0.
REQ-027 PEND[i] sets on a rising edge of ch_int_match[i], detected with a registered copy; a level held high sets once.
REQ-028 PEND write is write-1-to-clear; set and clear of the same bit in one cycle -> set wins.
REQ-029 Edges on disabled channels are not recorded.
REQ-030 irq is registered: one cycle after pending & mask becomes nonzero or zero.

Reset
REQ-031 On reset: FSM IDLE, ack=0, rdata=0, irq=0, all CONFIG=0 (so ch_reset all 1), ch_match=0, PEND=0, MASK=0, edge registers=0.
REQ-032 Reset asserted mid-transaction aborts it with no ack; after release the FSM is in IDLE.

Structure
REQ-033 Address constants, CONFIG field offsets, mode encodings and FSM state encodings live in a shared timer package/include also used by dev_timer.
REQ-034 One sub-module, timer_irq_ctrl (edge detect, pending, mask, irq), instantiated once and sized by NCH.

Verification
REQ-035 Write MATCH ch0 = 0x1234 -> ack at cycle +2, ch_match[15:0]=0x1234, ch_reset[0] unchanged.
REQ-036 ch0 enabled in normal mode; write CONFIG ch0 = 0x89 (en, CTC, clk 1) -> ch_reset[0] high 2 cycles, ack at cycle +4.
REQ-037 MASK=0x1, ch0 enabled, pulse ch_int_match[0] high for 3 cycles -> PEND=0x1 once, irq=1 one cycle later; write PEND=0x1 -> irq=0.
REQ-038 W1C of PEND bit 1 in the same cycle as a ch1 rising edge -> PEND[1] remains 1.
REQ-039 Read addr 0x1F and channel 5 (NCH=4) -> rdata=0, ack delivered.
REQ-040 Assert reset during QUIESCE -> no ack, all ch_reset=1, FSM IDLE after release; next read completes in 2 cycles.
